rp_counter: RTL and testbench
=============================

Name: rp_counter

Overview:
- Multi-mode pulse counter with a sys_bus register interface.
- Counts rising edges on inputs[0] (ch1) and inputs[1] (ch2).
- Supports free-run (immediate), triggered-window and gated acquisition; triggered/gated results go into a per-channel 4096-bin histogram memory.
- Sits behind the Red Pitaya system bus; inputs come from external digital pins.

Parameters:
N_BINS, 4096, depth of each channel's bin memory (power of 2)
CW, 32, counter/data width

Ports:
i_clk  in  1  system clock (125 MHz)
i_rstn  in  1  reset; one clock, synchronous, active-low
inputs  in  4  async digital inputs; [0]=ch1 count, [1]=ch2 count, [3:0] selectable trigger/gate source
sys_addr  in  32  bus byte address
sys_wdata  in  32  bus write data
sys_wen  in  1  write strobe, 1 cycle
sys_ren  in  1  read strobe, 1 cycle
sys_rdata  out  32  read data, valid with sys_ack
sys_err  out  1  always 0
sys_ack  out  1  transfer acknowledge pulse

Behaviour:
- Inputs pass a 2-FF synchronizer, then rising-edge detect; each detected edge increments that channel counter by 1 while a window is open.
- Registers (byte addr, R/W unless noted):
  - 0x00 write = command, read = state.
  - 0x04 timeout (window length in cycles).
  - 0x08 ch1 last count (RO), 0x0C ch2 last count (RO).
  - 0x10 nbins, 1..4096.
  - 0x14 extra repetitions per bin.
  - 0x18 predelay cycles.
  - 0x1C trigger config: [2:0] source input number 1..4, 0 = none; [15] polarity, 1 = active-high.
  - 0x20 bin index (RO).
- Bin memory (RO): 0x10000+4*i = ch1 bin i; 0x14000+4*i = ch2 bin i.
- Unmapped reads return 0; unmapped writes are ignored.
- Bus timing: register access acks 1 cycle after the strobe; memory read acks 2 cycles after (BRAM latency).
- Reset values: all registers 0, sys_ack=0, state 0, bin index 0. Memory contents are not cleared.
- State codes: 0 IDLE, 2 COUNT_IMM, 3 ARMED, 6 PREDELAY, 7 COUNT_TRIG, 8 GATED.
- Commands:
  - 0x01 abort: go to 0, discard the running window.
  - 0x02 reset: state 0, bin index 0, count registers 0, repetition counter 0.
  - 0x03 countImmediately: 0 -> 2.
  - 0x04 countTriggered: 0 -> 3.
  - 0x05 countGated: 0 -> 8.
  - 0x06 sw trigger: effective only in state 3.
  - Other commands are ignored in non-IDLE states, except 0x01, 0x02 and 0x06.
- COUNT_IMM:
  - Counters clear on entry and count for exactly timeout cycles.
  - Results latch into 0x08/0x0C; state -> 0; bins untouched.
- ARMED:
  - Exits on sw trigger, or on the selected source's active edge (the inactive->active transition defined by polarity).
  - Goes to 6 if predelay>0 (waits predelay cycles), else straight to 7.
- COUNT_TRIG:
  - Window of timeout cycles; at its end, the count is added into the current bin of each channel.
  - The first repetition overwrites the bin; later repetitions accumulate.
  - After reps+1 windows: bin index +1 and repetition counter cleared.
  - If bin index == nbins: state -> 0, else -> 3.
  - 0x08/0x0C also latch each window's count.
- GATED:
  - Window is open while the selected source is active; timeout is ignored.
  - The gate's inactive edge closes the window; storage follows the same rules as COUNT_TRIG.
  - Stays in 8 until bins are full, then -> 0.
- Source 0 in ARMED/GATED: no hardware trigger/gate; only sw trigger works.
- Simultaneous events:
  - Bus command beats an internal transition in the same cycle.
  - An edge that coincides with window close is counted in the closing window.
- Counters wrap modulo 2^32 (unless the optional feature is enabled).
- nbins=0 is treated as 4096.

Optional Feature:
COUNTER_SATURATE_EN:
- Defined: channel counters and bin accumulation saturate at 0xFFFFFFFF.
- Undefined: both wrap modulo 2^32.

Test Plan:
- Immediate count: timeout=1000; inputs[0] 1-cycle pulse every 100 cycles, inputs[1] high 10 of every 50 cycles; cmd 0x03.
  - State reads 2 during the window, 0 after ~1010 cycles.
  - 0x08 reads 10, 0x0C reads 20.
- Triggered, sw trigger: cmd 0x02 then 0x04 -> state 3, bin index 0; cmd 0x06 -> state 7; after 1010 cycles -> state 3, bin index 1, 0x10000=10, 0x14000=20.
- Triggered, hw trigger: config 0x8004; cmd 0x04; pulse inputs[3] high for 10 cycles.
  - State 7 within 10 cycles; bin 0 gets 10/20.
  - Bin index 1, state back to 3.
- Gated: cmd 0x05 -> state 8; inputs[3] high 1000 cycles then low.
  - After 10 cycles: bin index 1, state 8, 0x10000=10, 0x14000=20.
- Repetitions/bin-full: nbins=2, reps=1; 4 sw triggers.
  - Bin 0 = 20/40 and bin 1 = 20/40.
  - State 0 after the last window; a further trigger is ignored.
- Abort/reset mid-window: cmd 0x01 during state 7 -> state 0, bin index unchanged; cmd 0x02 -> bin index 0, 0x08=0.

Source files
------------

// File: rtl/rp_counter.sv
// -----------------------------------------------------------------------------
// rp_counter
//
// Pulse counter with two counting channels and a system-bus register file.
// Rising edges on inputs[0] (ch1) and inputs[1] (ch2) are counted while an
// acquisition window is open. There are three ways to open a window:
//   - immediate  : one window of `timeout` cycles, result only in 0x08/0x0C
//   - triggered  : sw or hw trigger, optional predelay, window of `timeout`
//   - gated      : window open while the selected input is active
// Triggered and gated results are stored in a per-channel bin memory.
// Each bin collects (reps+1) windows.
//
// Ports
//   i_clk      system clock
//   i_rstn     synchronous active-low reset
//   inputs     asynchronous pins: [0] ch1, [1] ch2, [3:0] trigger/gate source
//   sys_addr   bus byte address
//   sys_wdata  bus write data
//   sys_wen    write strobe (1 cycle)
//   sys_ren    read strobe (1 cycle)
//   sys_rdata  read data, valid while sys_ack is high
//   sys_err    tied to 0
//   sys_ack    acknowledge pulse
//
// Bus handshake: the master raises sys_wen or sys_ren for exactly one cycle.
// It then waits for the single-cycle sys_ack before issuing the next strobe.
// Register accesses ack one cycle after the strobe. Bin-memory reads ack two
// cycles after the strobe.
//
// Build option: define COUNTER_SATURATE_EN to make the channel counters and
// the bin accumulation saturate at all-ones. Without it they wrap around.
// -----------------------------------------------------------------------------
module rp_counter #(
    parameter int N_BINS = 4096,
    parameter int CW     = 32
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic [3:0]  inputs,
    input  logic [31:0] sys_addr,
    input  logic [31:0] sys_wdata,
    input  logic        sys_wen,
    input  logic        sys_ren,
    output logic [31:0] sys_rdata,
    output logic        sys_err,
    output logic        sys_ack
);
    localparam int AW = $clog2(N_BINS);
    localparam logic [AW:0]   BIN_ONE  = 1;
    localparam logic [AW+1:0] BIN_ONEX = 1;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_IMM   = 4'd2,
        S_ARMED = 4'd3,
        S_PRE   = 4'd6,
        S_TRIG  = 4'd7,
        S_GATED = 4'd8
    } state_t;

    localparam logic [31:0] CMD_ABORT  = 32'd1;
    localparam logic [31:0] CMD_RESET  = 32'd2;
    localparam logic [31:0] CMD_IMM    = 32'd3;
    localparam logic [31:0] CMD_TRIG   = 32'd4;
    localparam logic [31:0] CMD_GATED  = 32'd5;
    localparam logic [31:0] CMD_SWTRIG = 32'd6;

    function automatic logic [CW-1:0] f_add(input logic [CW-1:0] a, input logic [CW-1:0] b);
        logic [CW:0] s;
        s = {1'b0, a} + {1'b0, b};
`ifdef COUNTER_SATURATE_EN
        f_add = s[CW] ? {CW{1'b1}} : s[CW-1:0];
`else
        f_add = s[CW-1:0];
`endif
    endfunction

    // ---------------- registers ----------------
    state_t        r_state, w_state_nxt;
    logic [3:0]    r_sync1, r_sync2, r_sync_d;
    logic [31:0]   r_timeout, r_nbins, r_reps, r_predelay, r_timer, r_rep;
    logic [2:0]    r_trig_src;
    logic          r_trig_pol;
    logic [CW-1:0] r_cnt1, r_cnt2, r_last1, r_last2, r_acc1, r_acc2;
    logic [AW:0]   r_bin;
    logic [CW-1:0] r_mem1 [N_BINS];
    logic [CW-1:0] r_mem2 [N_BINS];
    logic [CW-1:0] r_mq1, r_mq2;
    logic          r_mem_pend, r_mem_sel2, r_ack;
    logic [31:0]   r_rdata;

    // ---------------- combinational ----------------
    logic [3:0]    w_rise;
    logic          w_src_ok, w_src_cur, w_src_prev, w_act, w_act_prev, w_act_rise, w_act_fall;
    logic [1:0]    w_src_idx;
    logic          w_cmd_wr, w_tmo_last, w_pre_last, w_bin_done, w_full;
    logic          w_win_start, w_cnt_en, w_close, w_store, w_clear;
    logic [CW-1:0] w_cnt1_nxt, w_cnt2_nxt, w_val1, w_val2;
    logic [AW:0]   w_nbins_eff;
    logic          w_mem1_hit, w_mem2_hit;
    logic [AW-1:0] w_mem_idx;
    logic [31:0]   w_reg_rdata;

    assign sys_err   = 1'b0;
    assign sys_ack   = r_ack;
    assign sys_rdata = r_rdata;

    // 2-FF synchronizer plus one more stage for edge detection.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_sync_d <= '0;
        end else begin
            r_sync1  <= inputs;
            r_sync2  <= r_sync1;
            r_sync_d <= r_sync2;
        end
    end

    assign w_rise = r_sync2 & ~r_sync_d;

    // Trigger/gate source: source number 1..4 selects inputs[n-1].
    // Polarity 1 means the source is active when high.
    assign w_src_ok   = (r_trig_src >= 3'd1) && (r_trig_src <= 3'd4);
    assign w_src_idx  = r_trig_src[1:0] - 2'd1;
    assign w_src_cur  = r_sync2[w_src_idx];
    assign w_src_prev = r_sync_d[w_src_idx];
    assign w_act      = w_src_ok && (w_src_cur == r_trig_pol);
    assign w_act_prev = w_src_ok && (w_src_prev == r_trig_pol);
    assign w_act_rise = w_act & ~w_act_prev;
    assign w_act_fall = ~w_act & w_act_prev;

    assign w_cnt1_nxt = f_add(r_cnt1, {{(CW-1){1'b0}}, w_rise[0]});
    assign w_cnt2_nxt = f_add(r_cnt2, {{(CW-1){1'b0}}, w_rise[1]});

    // The first repetition of a bin overwrites it. Later repetitions add to it.
    // r_acc mirrors the value most recently written to the current bin.
    assign w_val1 = (r_rep == '0) ? w_cnt1_nxt : f_add(r_acc1, w_cnt1_nxt);
    assign w_val2 = (r_rep == '0) ? w_cnt2_nxt : f_add(r_acc2, w_cnt2_nxt);

    // An nbins value of 0, or one beyond the memory depth, means full depth.
    assign w_nbins_eff = ((r_nbins == '0) || (r_nbins > 32'(N_BINS))) ?
                         (AW+1)'(N_BINS) : r_nbins[AW:0];
    assign w_bin_done  = (r_rep >= r_reps);
    assign w_full      = w_bin_done && (({1'b0, r_bin} + BIN_ONEX) >= {1'b0, w_nbins_eff});

    // The current cycle is the last one of the window or predelay.
    // A zero length therefore still yields one cycle.
    assign w_tmo_last = ({1'b0, r_timer} + 33'd1) >= {1'b0, r_timeout};
    assign w_pre_last = ({1'b0, r_timer} + 33'd1) >= {1'b0, r_predelay};

    assign w_cmd_wr = sys_wen && (sys_addr == 32'h0000_0000);

    // ---------------- FSM ----------------
    always_ff @(posedge i_clk) begin
        if (!i_rstn) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_win_start = 1'b0;
        w_cnt_en    = 1'b0;
        w_close     = 1'b0;
        w_store     = 1'b0;
        w_clear     = 1'b0;
        case (r_state)
            S_IDLE: ;
            S_IMM: begin
                w_cnt_en = 1'b1;
                if (w_tmo_last) begin
                    w_close     = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_ARMED: begin
                if (w_act_rise) begin
                    w_win_start = 1'b1;
                    w_state_nxt = (r_predelay != '0) ? S_PRE : S_TRIG;
                end
            end
            S_PRE: begin
                if (w_pre_last) begin
                    w_win_start = 1'b1;
                    w_state_nxt = S_TRIG;
                end
            end
            S_TRIG: begin
                w_cnt_en = 1'b1;
                if (w_tmo_last) begin
                    w_close     = 1'b1;
                    w_store     = 1'b1;
                    w_state_nxt = w_full ? S_IDLE : S_ARMED;
                end
            end
            S_GATED: begin
                // The closing cycle still counts, so an edge arriving together
                // with the gate's inactive edge belongs to that window.
                w_cnt_en = w_act | w_act_fall;
                if (w_act_fall) begin
                    w_close     = 1'b1;
                    w_store     = 1'b1;
                    w_state_nxt = w_full ? S_IDLE : S_GATED;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // A bus command takes priority over the internal transition above.
        if (w_cmd_wr) begin
            case (sys_wdata)
                CMD_ABORT: begin
                    w_state_nxt = S_IDLE;
                    w_win_start = 1'b0;
                    w_close     = 1'b0;
                    w_store     = 1'b0;
                end
                CMD_RESET: begin
                    w_state_nxt = S_IDLE;
                    w_win_start = 1'b0;
                    w_close     = 1'b0;
                    w_store     = 1'b0;
                    w_clear     = 1'b1;
                end
                CMD_IMM: begin
                    if (r_state == S_IDLE) begin
                        w_state_nxt = S_IMM;
                        w_win_start = 1'b1;
                    end
                end
                CMD_TRIG: begin
                    if (r_state == S_IDLE) w_state_nxt = S_ARMED;
                end
                CMD_GATED: begin
                    if (r_state == S_IDLE) begin
                        w_state_nxt = S_GATED;
                        w_win_start = 1'b1;
                    end
                end
                CMD_SWTRIG: begin
                    if (r_state == S_ARMED) begin
                        w_win_start = 1'b1;
                        w_state_nxt = (r_predelay != '0) ? S_PRE : S_TRIG;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- datapath and config registers ----------------
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_timeout  <= '0;
            r_nbins    <= '0;
            r_reps     <= '0;
            r_predelay <= '0;
            r_trig_src <= '0;
            r_trig_pol <= 1'b0;
            r_timer    <= '0;
            r_rep      <= '0;
            r_cnt1     <= '0;
            r_cnt2     <= '0;
            r_last1    <= '0;
            r_last2    <= '0;
            r_acc1     <= '0;
            r_acc2     <= '0;
            r_bin      <= '0;
        end else begin
            if (sys_wen) begin
                case (sys_addr)
                    32'h04: r_timeout  <= sys_wdata;
                    32'h10: r_nbins    <= sys_wdata;
                    32'h14: r_reps     <= sys_wdata;
                    32'h18: r_predelay <= sys_wdata;
                    32'h1C: begin
                        r_trig_src <= sys_wdata[2:0];
                        r_trig_pol <= sys_wdata[15];
                    end
                    default: ;
                endcase
            end

            if (w_win_start)
                r_timer <= '0;
            else if ((r_state == S_IMM) || (r_state == S_PRE) || (r_state == S_TRIG))
                r_timer <= r_timer + 32'd1;

            if (w_clear || w_win_start || w_close) begin
                r_cnt1 <= '0;
                r_cnt2 <= '0;
            end else if (w_cnt_en) begin
                r_cnt1 <= w_cnt1_nxt;
                r_cnt2 <= w_cnt2_nxt;
            end

            if (w_clear) begin
                r_last1 <= '0;
                r_last2 <= '0;
            end else if (w_close) begin
                r_last1 <= w_cnt1_nxt;
                r_last2 <= w_cnt2_nxt;
            end

            if (w_clear) begin
                r_bin <= '0;
                r_rep <= '0;
            end else if (w_store) begin
                r_acc1 <= w_val1;
                r_acc2 <= w_val2;
                if (w_bin_done) begin
                    r_bin <= r_bin + BIN_ONE;
                    r_rep <= '0;
                end else begin
                    r_rep <= r_rep + 32'd1;
                end
            end
        end
    end

    // ---------------- bin memories (contents survive reset) ----------------
    assign w_mem1_hit = (sys_addr[31:14] == 18'h4);   // 0x10000..0x13FFF
    assign w_mem2_hit = (sys_addr[31:14] == 18'h5);   // 0x14000..0x17FFF
    assign w_mem_idx  = sys_addr[AW+1:2];

    always_ff @(posedge i_clk) begin
        if (w_store) begin
            r_mem1[r_bin[AW-1:0]] <= w_val1;
            r_mem2[r_bin[AW-1:0]] <= w_val2;
        end
        r_mq1 <= r_mem1[w_mem_idx];
        r_mq2 <= r_mem2[w_mem_idx];
    end

    // ---------------- bus read path ----------------
    always_comb begin
        w_reg_rdata = '0;
        case (sys_addr)
            32'h00: w_reg_rdata = {28'd0, r_state};
            32'h04: w_reg_rdata = r_timeout;
            32'h08: w_reg_rdata = 32'(r_last1);
            32'h0C: w_reg_rdata = 32'(r_last2);
            32'h10: w_reg_rdata = r_nbins;
            32'h14: w_reg_rdata = r_reps;
            32'h18: w_reg_rdata = r_predelay;
            32'h1C: w_reg_rdata = {16'd0, r_trig_pol, 12'd0, r_trig_src};
            32'h20: w_reg_rdata = 32'(r_bin);
            default: w_reg_rdata = '0;
        endcase
    end

    // Memory reads take one cycle in the RAM output register (r_mq*) and a
    // second in r_rdata, which gives the two-cycle ack.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_ack      <= 1'b0;
            r_rdata    <= '0;
            r_mem_pend <= 1'b0;
            r_mem_sel2 <= 1'b0;
        end else begin
            r_ack      <= 1'b0;
            r_mem_pend <= 1'b0;
            if (r_mem_pend) begin
                r_ack   <= 1'b1;
                r_rdata <= 32'(r_mem_sel2 ? r_mq2 : r_mq1);
            end else if (sys_wen) begin
                r_ack <= 1'b1;
            end else if (sys_ren) begin
                if (w_mem1_hit || w_mem2_hit) begin
                    r_mem_pend <= 1'b1;
                    r_mem_sel2 <= w_mem2_hit;
                end else begin
                    r_ack   <= 1'b1;
                    r_rdata <= w_reg_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_rp_counter.sv
// -----------------------------------------------------------------------------
// tb_rp_counter
//
// Directed bench for rp_counter. The pin pattern runs continuously:
//   - ch1 is a 1-cycle pulse every 100 cycles
//   - ch2 is high for 10 of every 50 cycles
// Any 1000-cycle window therefore sees 10 ch1 edges and 20 ch2 edges.
// inputs[3] serves as the hw trigger/gate pin.
// -----------------------------------------------------------------------------
module tb_rp_counter;
    // ---------------- clock / reset ----------------
    logic        i_clk = 1'b0;
    logic        i_rstn;
    logic [3:0]  inputs;
    logic [31:0] sys_addr, sys_wdata, sys_rdata;
    logic        sys_wen, sys_ren, sys_err, sys_ack;

    always #4 i_clk = ~i_clk;

    rp_counter dut (
        .i_clk    (i_clk),
        .i_rstn   (i_rstn),
        .inputs   (inputs),
        .sys_addr (sys_addr),
        .sys_wdata(sys_wdata),
        .sys_wen  (sys_wen),
        .sys_ren  (sys_ren),
        .sys_rdata(sys_rdata),
        .sys_err  (sys_err),
        .sys_ack  (sys_ack)
    );

    int n_vec;
    int n_err;
    int pc;
    int gate_left;
    logic [31:0] d;
    int lat;

    // ---------------- scoreboard check ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Advance one clock; inputs change 1 ns after the edge.
    task automatic cyc();
        logic in0, in1, gate;
        @(posedge i_clk);
        #1;
        in0  = ((pc % 100) == 5);
        in1  = ((pc % 50) >= 5) && ((pc % 50) < 15);
        gate = (gate_left > 0);
        if (gate_left > 0) gate_left--;
        pc++;
        inputs = {gate, 1'b0, in1, in0};
    endtask

    task automatic wait_cyc(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        sys_addr  = addr;
        sys_wdata = data;
        sys_wen   = 1'b1;
        cyc();
        sys_wen   = 1'b0;
        chk("wr_ack", 32'(sys_ack), 32'd1);
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data, output int l);
        sys_addr = addr;
        sys_ren  = 1'b1;
        cyc();
        sys_ren  = 1'b0;
        l = 1;
        while ((sys_ack !== 1'b1) && (l < 5)) begin
            cyc();
            l++;
        end
        chk("rd_ack", 32'(sys_ack), 32'd1);
        data = sys_rdata;
    endtask

    task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] v;
        int l;
        bus_read(addr, v, l);
        chk(tag, v, exp);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        n_vec = 0; n_err = 0; pc = 0; gate_left = 0;
        i_rstn = 1'b0; inputs = '0;
        sys_addr = '0; sys_wdata = '0; sys_wen = 1'b0; sys_ren = 1'b0;
        wait_cyc(3);
        chk("rst_ack", 32'(sys_ack), 32'd0);
        chk("err", 32'(sys_err), 32'd0);
        i_rstn = 1'b1;
        cyc();

        // reset values
        rd("rst_state", 32'h00, 32'd0);
        rd("rst_timeout", 32'h04, 32'd0);
        rd("rst_cnt1", 32'h08, 32'd0);
        rd("rst_cnt2", 32'h0C, 32'd0);
        rd("rst_nbins", 32'h10, 32'd0);
        rd("rst_bin", 32'h20, 32'd0);
        bus_read(32'h1C, d, lat);
        chk("rst_trig", d, 32'd0);
        chk("reg_lat", 32'(lat), 32'd1);

        // unmapped access
        bus_write(32'h24, 32'hFFFF);
        rd("unmapped", 32'h24, 32'd0);

        // immediate count
        bus_write(32'h04, 32'd1000);
        rd("timeout_rb", 32'h04, 32'd1000);
        bus_write(32'h00, 32'd3);
        rd("imm_state", 32'h00, 32'd2);
        wait_cyc(1010);
        rd("imm_done", 32'h00, 32'd0);
        rd("imm_cnt1", 32'h08, 32'd10);
        rd("imm_cnt2", 32'h0C, 32'd20);

        // triggered, sw trigger
        bus_write(32'h00, 32'd2);
        bus_write(32'h00, 32'd4);
        rd("sw_armed", 32'h00, 32'd3);
        rd("sw_bin0", 32'h20, 32'd0);
        bus_write(32'h00, 32'd3);
        rd("ignored_cmd", 32'h00, 32'd3);
        bus_write(32'h00, 32'd6);
        rd("sw_count", 32'h00, 32'd7);
        wait_cyc(1010);
        rd("sw_rearm", 32'h00, 32'd3);
        rd("sw_bin1", 32'h20, 32'd1);
        bus_read(32'h10000, d, lat);
        chk("sw_mem1", d, 32'd10);
        chk("mem_lat", 32'(lat), 32'd2);
        rd("sw_mem2", 32'h14000, 32'd20);
        rd("sw_last1", 32'h08, 32'd10);

        // triggered, hw trigger on inputs[3], active-high
        bus_write(32'h1C, 32'h8004);
        rd("trig_rb", 32'h1C, 32'h8004);
        bus_write(32'h00, 32'd2);
        bus_write(32'h00, 32'd4);
        rd("hw_armed", 32'h00, 32'd3);
        gate_left = 10;
        wait_cyc(10);
        rd("hw_count", 32'h00, 32'd7);
        wait_cyc(1010);
        rd("hw_rearm", 32'h00, 32'd3);
        rd("hw_bin1", 32'h20, 32'd1);
        rd("hw_mem1", 32'h10000, 32'd10);
        rd("hw_mem2", 32'h14000, 32'd20);

        // gated, gate aligned to the pattern so no edge sits on the boundary
        bus_write(32'h00, 32'd2);
        bus_write(32'h00, 32'd5);
        rd("gate_state", 32'h00, 32'd8);
        pc = 0;
        gate_left = 1000;
        wait_cyc(1010);
        rd("gate_bin1", 32'h20, 32'd1);
        rd("gate_stay", 32'h00, 32'd8);
        rd("gate_mem1", 32'h10000, 32'd10);
        rd("gate_mem2", 32'h14000, 32'd20);

        // repetitions and bins-full
        bus_write(32'h00, 32'd2);
        bus_write(32'h1C, 32'd0);
        bus_write(32'h10, 32'd2);
        bus_write(32'h14, 32'd1);
        bus_write(32'h00, 32'd4);
        for (int k = 0; k < 4; k++) begin
            bus_write(32'h00, 32'd6);
            wait_cyc(1010);
            rd("rep_state", 32'h00, (k == 3) ? 32'd0 : 32'd3);
        end
        rd("rep_bin", 32'h20, 32'd2);
        rd("rep_last1", 32'h08, 32'd10);
        rd("rep_b0c1", 32'h10000, 32'd20);
        rd("rep_b1c1", 32'h10004, 32'd20);
        rd("rep_b0c2", 32'h14000, 32'd40);
        rd("rep_b1c2", 32'h14004, 32'd40);
        bus_write(32'h00, 32'd6);
        rd("full_ignore", 32'h00, 32'd0);
        rd("full_bin", 32'h20, 32'd2);

        // abort and reset mid-window
        bus_write(32'h14, 32'd0);
        bus_write(32'h00, 32'd2);
        bus_write(32'h00, 32'd4);
        bus_write(32'h00, 32'd6);
        wait_cyc(1010);
        rd("ab_bin1", 32'h20, 32'd1);
        bus_write(32'h00, 32'd6);
        rd("ab_count", 32'h00, 32'd7);
        wait_cyc(100);
        bus_write(32'h00, 32'd1);
        rd("ab_state", 32'h00, 32'd0);
        rd("ab_bin", 32'h20, 32'd1);
        rd("ab_last1", 32'h08, 32'd10);
        bus_write(32'h00, 32'd2);
        rd("rs_bin", 32'h20, 32'd0);
        rd("rs_cnt1", 32'h08, 32'd0);
        rd("rs_cnt2", 32'h0C, 32'd0);

        // predelay
        bus_write(32'h18, 32'd50);
        bus_write(32'h00, 32'd4);
        bus_write(32'h00, 32'd6);
        rd("pre_state", 32'h00, 32'd6);
        wait_cyc(60);
        rd("pre_count", 32'h00, 32'd7);
        bus_write(32'h00, 32'd1);
        rd("pre_abort", 32'h00, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
